// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// FSM state encoding, default operand width, ALUFlags bit positions.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (shift, trial-subtract, select).
// Ports: rem/quot/dvs in; rem_next/quot_next out. Purely combinational.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  // Shifted remainder needs one extra bit: it can reach 2*dvs-1.
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    sh        = {rem, quot[WIDTH-1]};
    ge        = (sh >= {1'b0, dvs});
    diff      = sh - {1'b0, dvs};
    rem_next  = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: quotient, remainder and {N,Z,C,V} flags.
// Ports: clk, reset (async, low), start, a, b, [is_signed], busy, done,
// Result, Result2, ALUFlags. Signed mode enabled by macro DIV_SIGNED_EN.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result2,
  output logic [3:0]       ALUFlags
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             ovf;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             ovf_in;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef DIV_SIGNED_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b0;
`endif

  // Most-negative / -1 overflows; magnitude path still yields MIN.
  always_comb begin
    a_neg  = sgn & a[WIDTH-1];
    b_neg  = sgn & b[WIDTH-1];
    a_mag  = a_neg ? (~a + 1'b1) : a;
    b_mag  = b_neg ? (~b + 1'b1) : b;
    ovf_in = sgn && (a == {1'b1, {(WIDTH-1){1'b0}}})
                 && (b == {WIDTH{1'b1}});
    q_fin  = neg_q ? (~quot_next + 1'b1) : quot_next;
    r_fin  = neg_r ? (~rem_next + 1'b1) : rem_next;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .quot      (quot),
    .dvs       (dvs),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Result   <= '0;
      Result2  <= '0;
      ALUFlags <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            ovf   <= ovf_in;
            cnt   <= '0;
            rem   <= '0;
            quot  <= a_mag;
            dvs   <= b_mag;
            if (b == '0) begin
              state            <= DONE;
              done             <= 1'b1;
              Result           <= '1;
              Result2          <= a;
              ALUFlags         <= '0;
              ALUFlags[FLAG_N] <= 1'b1;
              ALUFlags[FLAG_V] <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem  <= rem_next;
          quot <= quot_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            state            <= DONE;
            done             <= 1'b1;
            Result           <= q_fin;
            Result2          <= r_fin;
            ALUFlags[FLAG_N] <= q_fin[WIDTH-1];
            ALUFlags[FLAG_Z] <= (q_fin == '0) && (r_fin == '0);
            ALUFlags[FLAG_C] <= 1'b0;
            ALUFlags[FLAG_V] <= ovf;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, random vs model,
// mid-CALC start, start during done, and mid-CALC reset sequences.
module tb_seq_divider;

  localparam int W = 32;

`ifdef DIV_SIGNED_EN
  localparam bit HAS_S = 1'b1;
`else
  localparam bit HAS_S = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         is_signed = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic [W-1:0] Result2;
  logic [3:0]   ALUFlags;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef DIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .busy     (busy),
    .done     (done),
    .Result   (Result),
    .Result2  (Result2),
    .ALUFlags (ALUFlags)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [3:0]   f;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [3:0]   f;
    int           lat;
  } vec_t;

  // Reference: plain arithmetic on integers, signed via $signed.
  function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, bit s);
    res_t o;
    bit   v;
    v = 1'b0;
    if (y == 0) begin
      o.q = '1;
      o.r = x;
      v   = 1'b1;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      o.q = x;
      o.r = '0;
      v   = 1'b1;
    end else if (s) begin
      o.q = $signed(x) / $signed(y);
      o.r = $signed(x) % $signed(y);
    end else begin
      o.q = x / y;
      o.r = x % y;
    end
    o.f = {o.q[W-1], (o.q == 0 && o.r == 0), 1'b0, v};
    return o;
  endfunction

  // Drives one request; lat counts edges from the accepting edge (=1)
  // until done is seen. 100 means done never came.
  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y,
                     input bit s, output res_t got, output int lat);
    @(negedge clk);
    a = x;
    b = y;
    is_signed = s;
    start = 1'b1;
    lat = 100;
    for (int i = 1; i < 100; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    got.q = Result;
    got.r = Result2;
    got.f = ALUFlags;
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
  endtask

  vec_t vt[$];
  res_t got;
  res_t exp_r;
  int   lat;

  initial begin
    vt.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 4'b0000, 33});
    vt.push_back('{32'd5, 32'd0, 1'b0, '1, 32'd5, 4'b1001, 1});
    vt.push_back('{32'd0, 32'd9, 1'b0, 32'd0, 32'd0, 4'b0100, 33});
    vt.push_back('{32'd0, 32'd0, 1'b0, '1, 32'd0, 4'b1001, 1});
    vt.push_back('{'1, 32'd1, 1'b0, '1, 32'd0, 4'b1000, 33});
    vt.push_back('{32'd7, 32'd100, 1'b0, 32'd0, 32'd7, 4'b0000, 33});
    vt.push_back('{'1, '1, 1'b0, 32'd1, 32'd0, 4'b0000, 33});
    vt.push_back('{32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1,
                   4'b0000, 33});
    if (HAS_S) begin
      vt.push_back('{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD,
                     32'hFFFF_FFFF, 4'b1000, 33});
      vt.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000,
                     32'd0, 4'b1001, 33});
      vt.push_back('{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD,
                     32'd1, 4'b1000, 33});
      vt.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3,
                     32'hFFFF_FFFF, 4'b0000, 33});
      vt.push_back('{32'hFFFF_FFF9, 32'd0, 1'b1, '1,
                     32'hFFFF_FFF9, 4'b1001, 1});
    end

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", Result, 0);
    check("rst_r", Result2, 0);
    check("rst_f", ALUFlags, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vt[i]) begin
      run(vt[i].a, vt[i].b, vt[i].s, got, lat);
      check($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      check($sformatf("vec%0d_q", i), got.q, vt[i].q);
      check($sformatf("vec%0d_r", i), got.r, vt[i].r);
      check($sformatf("vec%0d_f", i), got.f, vt[i].f);
    end

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      bit           s;
      x = $urandom;
      y = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) y = '0;
      s = HAS_S ? 1'($urandom_range(0, 1)) : 1'b0;
      exp_r = model(x, y, s);
      run(x, y, s, got, lat);
      check($sformatf("rnd%0d_lat", i), lat, (y == 0) ? 1 : 33);
      check($sformatf("rnd%0d_q", i), got.q, exp_r.q);
      check($sformatf("rnd%0d_r", i), got.r, exp_r.r);
      check($sformatf("rnd%0d_f", i), got.f, exp_r.f);
    end

    // Second start mid-CALC, then start during the done cycle.
    @(negedge clk);
    a = 32'd100;
    b = 32'd7;
    is_signed = 1'b0;
    start = 1'b1;
    lat = 100;
    for (int i = 1; i < 100; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (i >= 5 && i <= 7) begin
        a = 32'd20;
        b = 32'd3;
        start = 1'b1;
        check($sformatf("mid_busy%0d", i), busy, 1);
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    check("mid_lat", lat, 33);
    check("mid_q", Result, 14);
    check("mid_r", Result2, 2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("donecyc_busy", busy, 0);
    @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_q", Result, 14);

    // Asynchronous reset partway through CALC.
    @(negedge clk);
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    repeat (11) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("pre_rst_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", Result, 0);
    check("arst_r", Result2, 0);
    check("arst_f", ALUFlags, 0);
    @(negedge clk);
    reset = 1'b1;
    run(32'd9, 32'd3, 1'b0, got, lat);
    check("post_lat", lat, 33);
    check("post_q", got.q, 3);
    check("post_r", got.r, 0);
    check("post_f", got.f, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request pulse; operands sampled when accepted.
REQ-005 The block SHALL have port a  input  WIDTH  dividend.
REQ-006 The block SHALL have port b  input  WIDTH  divisor.
REQ-007 The block SHALL have port is_signed  input  1  signed (SDIV) vs unsigned (UDIV); present only with DIV_SIGNED_EN.
REQ-008 The block SHALL have port busy  output  1  high while a division is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-010 The block SHALL have port Result  output  WIDTH  quotient.
REQ-011 The block SHALL have port Result2  output  WIDTH  remainder.
REQ-012 The block SHALL have port ALUFlags  output  4  {N,Z,C,V} of the completed division.

Function
REQ-013 The block SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
- IDLE: start=1 latches a, b, is_signed; goes to CALC, or to DONE if b==0.
- CALC: one restoring-division step per cycle, WIDTH steps, then DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
REQ-014 Latency SHALL be exact: start accepted at edge 0 -> done high in cycle after edge WIDTH+1 (33 for WIDTH=32); divide-by-zero -> done after edge 1.
REQ-015 busy SHALL be 1 in CALC and DONE and 0 in IDLE; start SHALL be ignored while busy=1.
REQ-016 start in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-017 Each step SHALL shift {rem,quot} left 1, trial-subtract the divisor magnitude from rem, and keep the difference with quotient bit 1 when non-negative, else restore with bit 0.
REQ-018 Result/Result2/ALUFlags SHALL update only on entry to DONE and hold until the next completion.
REQ-019 Divide by zero SHALL give Result=all ones, Result2=dividend, V=1.
REQ-020 Flags SHALL be N=Result[MSB], Z=(Result==0 && Result2==0), C=0, V=divide-by-zero or signed overflow.

Reset
REQ-021 reset low SHALL, asynchronously, force IDLE, busy=0, done=0, Result=0, Result2=0, ALUFlags=0 and clear internal registers, including mid-CALC.
REQ-022 The first start SHALL be accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-023 With macro DIV_SIGNED_EN defined, is_signed SHALL exist; signed mode divides operand magnitudes, negates the quotient if operand signs differ and gives the remainder the dividend's sign.
REQ-024 With DIV_SIGNED_EN, 0x80000000 / 0xFFFFFFFF signed SHALL give Result=0x80000000, Result2=0, V=1, with normal latency.
REQ-025 Without DIV_SIGNED_EN, is_signed SHALL be absent and all division SHALL be unsigned.

Structure
REQ-026 Package div_pkg SHALL hold the FSM state typedef (IDLE, CALC, DONE), default WIDTH constant and flag bit-index constants (N=3, Z=2, C=1, V=0).
REQ-027 Sub-module div_step SHALL be the combinational single-iteration shift/trial-subtract/select; seq_divider SHALL hold FSM, step counter, operand/sign registers and output registers.

Verification
REQ-028 Unsigned 100/7 -> done 33 cycles after start, Result=14, Result2=2, ALUFlags=0000.
REQ-029 Unsigned 5/0 -> done 1 cycle after start, Result=0xFFFFFFFF, Result2=5, ALUFlags=1001.
REQ-030 Signed -7/2 -> Result=0xFFFFFFFD, Result2=0xFFFFFFFF, N=1, V=0; signed 0x80000000/-1 -> Result=0x80000000, Result2=0, V=1.
REQ-031 0/9 -> Result=0, Result2=0, ALUFlags=0100.
REQ-032 Second start (20/3) asserted mid-CALC of 100/7 -> ignored; only result 14 r2 returned, busy unchanged.
REQ-033 reset low at cycle 10 of CALC -> busy=0, done=0, outputs 0 immediately; a new 9/3 start after release -> 3 r0 in 33 cycles.
